rv_fetch_unit: RTL and testbench
================================

// Module: rv_fetch_unit
// PURPOSE
//  Instruction fetch stage of risc_v_processor; sits directly upstream of decode.
//  Owns the PC and issues word requests to a synchronous-read instruction memory.
//  Buffers returned words with their PC and hands them to decode over valid/ready.
//  Accepts branch/jump redirects from execute and flushes stale fetches.
// PARAMETERS
//  XLEN        32            address/PC width
//  RESET_PC    32'h0000_0000 first fetch address after reset
//  BUF_DEPTH   2             instruction buffer entries (>=2)
// PORTS
//  clock           in   1     single clock, rising edge
//  reset           in   1     synchronous, active-high
//  imem_req        out  1     read request this cycle
//  imem_addr       out  XLEN  byte address, [1:0] always 2'b00
//  imem_rdata      in   32    read data, valid the cycle after imem_req
//  redirect_valid  in   1     redirect request from execute
//  redirect_pc     in   XLEN  redirect target
//  if_valid        out  1     instruction available to decode
//  if_ready        in   1     decode accepts this cycle
//  if_instr        out  32    instruction word
//  if_pc           out  XLEN  PC of if_instr
//  fetch_fault     out  1     sticky misaligned-redirect error
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, buffer empty, inflight=0, if_valid=0,
//   if_instr=32'h0000_0013 (NOP), if_pc=0, imem_req=0, fetch_fault=0.
//  Issue rule: imem_req=1 when !reset && !redirect_valid && !fetch_fault
//   && (count + inflight - pop) < BUF_DEPTH; pop = if_valid && if_ready.
//   imem_addr=fetch_pc; on issue fetch_pc<=fetch_pc+4 (mod 2^XLEN, wraps).
//  inflight<=imem_req; req_pc latched with the request.
//  Response: cycle after issue, {imem_rdata, req_pc} pushed into buffer
//   unless killed. Push and pop in the same cycle are legal.
//  Output: if_valid/if_instr/if_pc from buffer head; stable while !if_ready.
//  Latency: reset low at cycle 0 -> req(RESET_PC) cycle 0, data cycle 1,
//   if_valid cycle 2. Steady state 1 instr/cycle with if_ready=1.
//  Redirect (cycle N): has priority over everything; buffer flushed,
//   response arriving in N+1 killed, fetch_pc<=redirect_pc, no req in N.
//   A concurrent pop in N is discarded. First req N+1, if_valid N+3.
//  Misaligned redirect (redirect_pc[1:0]!=0): fetch_fault<=1, buffer flushed,
//   all requests stop until reset; if_valid stays 0.
//  Buffer full: no request issued; never overflow, never drop a response.
//  Reset mid-operation: returns to reset state next edge, in-flight data dropped.
// STRUCTURE
//  rv_pkg: XLEN, ILEN=32, INSTR_NOP=32'h0000_0013, PC_STEP=4.
//  Sub-module rv_fetch_buffer: BUF_DEPTH FIFO of {instr,pc} with
//   push/pop/flush, count output; pointer wrap by modulo-depth counters.
//  Top holds PC, inflight/kill flag, issue logic, fault flag.
// TESTING
//  Reset release, memory word k=0x1000_0000+k, if_ready=1 -> if_valid at
//   cycle 2, if_pc 0,4,8,... one per cycle, instr matches.
//  if_ready=0 for 5 cycles -> at most BUF_DEPTH buffered, imem_req drops,
//   if_instr/if_pc held; resume -> no skipped or duplicated PC.
//  redirect_valid with redirect_pc=0x100 while buffer full -> stale words
//   never presented; next presented if_pc=0x100 at N+3, then 0x104.
//  redirect_pc=0x102 -> fetch_fault=1 next cycle, imem_req stays 0,
//   if_valid 0 until reset; reset clears fault, fetch restarts at RESET_PC.
//  Redirect to 0xFFFF_FFF8 -> if_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
//  reset asserted with inflight=1 and buffer non-empty -> next cycle all
//   outputs at reset values, in-flight word never appears on if_instr.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared constants and helpers for the RISC-V fetch slice.
package rv_pkg;
    localparam int XLEN    = 32;
    localparam int ILEN    = 32;
    localparam int PC_STEP = 4;
    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction
endpackage

// File: rtl/rv_fetch_buffer.sv
// Small FIFO of {instr, pc} pairs between the fetch PC logic and decode.
module rv_fetch_buffer
    import rv_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int PC_W  = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [ILEN-1:0]  push_instr_i,
    input  logic [PC_W-1:0]  push_pc_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             valid_o,
    output logic [ILEN-1:0]  instr_o,
    output logic [PC_W-1:0]  pc_o,
    output logic [CNT_W-1:0] count_o
);
    logic [ILEN-1:0]  instr_q [DEPTH];
    logic [PC_W-1:0]  pc_q    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap at DEPTH so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i  && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            instr_q[wr_ptr_q] <= push_instr_i;
            pc_q[wr_ptr_q]    <= push_pc_i;
        end
    end

    // An empty buffer presents a NOP at PC 0 rather than stale contents.
    assign valid_o = (count_q != '0);
    assign instr_o = valid_o ? instr_q[rd_ptr_q] : INSTR_NOP;
    assign pc_o    = valid_o ? pc_q[rd_ptr_q]    : '0;
    assign count_o = count_q;
endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem reads, buffers words for decode.
module rv_fetch_unit
    import rv_pkg::*;
#(
    parameter  int             XLEN      = rv_pkg::XLEN,
    parameter  logic [XLEN-1:0] RESET_PC = '0,
    parameter  int             BUF_DEPTH = 2,
    localparam int             CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            fetch_fault
);
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W:0]   occupancy;
    logic             pop, push;

    assign pop = if_valid && if_ready;

    // Slots already claimed once this cycle's pop and the outstanding response settle.
    assign occupancy = (CNT_W+1)'(buf_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);

    assign imem_req  = !reset && !redirect_valid && !fault_q
                       && (occupancy < (CNT_W+1)'(BUF_DEPTH));
    assign imem_addr = fetch_pc_q;

    // A redirect in the response cycle kills the returning word.
    assign push = inflight_q && !redirect_valid && !fault_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = imem_req;
        fault_d    = fault_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            fault_d    = fault_q || is_misaligned(redirect_pc[1:0]);
        end else if (imem_req) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        end
        if (imem_req) req_pc_d = fetch_pc_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
            inflight_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            fault_q    <= fault_d;
        end
    end

    always_ff @(posedge clock) begin
        req_pc_q <= req_pc_d;
    end

    rv_fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .PC_W  (XLEN)
    ) u_buf (
        .clk_i        (clock),
        .rst_i        (reset),
        .push_i       (push),
        .push_instr_i (imem_rdata),
        .push_pc_i    (req_pc_q),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .valid_o      (if_valid),
        .instr_o      (if_instr),
        .pc_o         (if_pc),
        .count_o      (buf_count)
    );

    assign fetch_fault = fault_q;
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed cycle-by-cycle bench for rv_fetch_unit with a word-indexed memory model.
module tb_rv_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_fault;
    } vec_t;

    vec_t tbl[33];

    rv_fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    // Synchronous-read instruction memory: data the cycle after the request.
    always @(posedge clock) begin
        if (imem_req) imem_rdata <= word_at(imem_addr);
    end

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc,
                                input logic e_fault);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic rst_v, input vec_t v);
        @(negedge clock);
        reset          = rst_v;
        if_ready       = v.rdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        #1;
        chk({tag, " imem_req"}, 32'(imem_req), 32'(v.e_req));
        if (v.e_req) chk({tag, " imem_addr"}, imem_addr, v.e_addr);
        chk({tag, " if_valid"}, 32'(if_valid), 32'(v.e_valid));
        if (v.e_valid) begin
            chk({tag, " if_pc"}, if_pc, v.e_pc);
            chk({tag, " if_instr"}, if_instr, word_at(v.e_pc));
        end
        chk({tag, " fetch_fault"}, 32'(fetch_fault), 32'(v.e_fault));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rst if_valid"}, 32'(if_valid), 32'd0);
        chk({tag, " rst if_instr"}, if_instr, NOP);
        chk({tag, " rst if_pc"}, if_pc, 32'd0);
        chk({tag, " rst fetch_fault"}, 32'(fetch_fault), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // rows: rdy rv rpc | req addr | valid pc | fault
        tbl[0]  = mk(1, 0, 0,            1, 32'h0,         0, 0,            0);
        tbl[1]  = mk(1, 0, 0,            1, 32'h4,         0, 0,            0);
        tbl[2]  = mk(1, 0, 0,            1, 32'h8,         1, 32'h0,        0);
        tbl[3]  = mk(1, 0, 0,            1, 32'hC,         1, 32'h4,        0);
        tbl[4]  = mk(1, 0, 0,            1, 32'h10,        1, 32'h8,        0);
        tbl[5]  = mk(0, 0, 0,            0, 0,             1, 32'hC,        0);
        tbl[6]  = mk(0, 0, 0,            0, 0,             1, 32'hC,        0);
        tbl[7]  = mk(0, 0, 0,            0, 0,             1, 32'hC,        0);
        tbl[8]  = mk(0, 0, 0,            0, 0,             1, 32'hC,        0);
        tbl[9]  = mk(0, 0, 0,            0, 0,             1, 32'hC,        0);
        tbl[10] = mk(1, 0, 0,            1, 32'h14,        1, 32'hC,        0);
        tbl[11] = mk(1, 0, 0,            1, 32'h18,        1, 32'h10,       0);
        tbl[12] = mk(1, 0, 0,            1, 32'h1C,        1, 32'h14,       0);
        tbl[13] = mk(1, 0, 0,            1, 32'h20,        1, 32'h18,       0);
        tbl[14] = mk(0, 0, 0,            0, 0,             1, 32'h1C,       0);
        tbl[15] = mk(0, 0, 0,            0, 0,             1, 32'h1C,       0);
        tbl[16] = mk(1, 1, 32'h100,      0, 0,             1, 32'h1C,       0);
        tbl[17] = mk(1, 0, 0,            1, 32'h100,       0, 0,            0);
        tbl[18] = mk(1, 0, 0,            1, 32'h104,       0, 0,            0);
        tbl[19] = mk(1, 0, 0,            1, 32'h108,       1, 32'h100,      0);
        tbl[20] = mk(1, 0, 0,            1, 32'h10C,       1, 32'h104,      0);
        tbl[21] = mk(1, 1, 32'hFFFF_FFF8, 0, 0,            1, 32'h108,      0);
        tbl[22] = mk(1, 0, 0,            1, 32'hFFFF_FFF8, 0, 0,            0);
        tbl[23] = mk(1, 0, 0,            1, 32'hFFFF_FFFC, 0, 0,            0);
        tbl[24] = mk(1, 0, 0,            1, 32'h0,         1, 32'hFFFF_FFF8, 0);
        tbl[25] = mk(1, 0, 0,            1, 32'h4,         1, 32'hFFFF_FFFC, 0);
        tbl[26] = mk(1, 0, 0,            1, 32'h8,         1, 32'h0,        0);
        tbl[27] = mk(1, 0, 0,            1, 32'hC,         1, 32'h4,        0);
        tbl[28] = mk(1, 1, 32'h102,      0, 0,             1, 32'h8,        0);
        tbl[29] = mk(1, 0, 0,            0, 0,             0, 0,            1);
        tbl[30] = mk(1, 0, 0,            0, 0,             0, 0,            1);
        tbl[31] = mk(1, 1, 32'h100,      0, 0,             0, 0,            1);
        tbl[32] = mk(1, 0, 0,            0, 0,             0, 0,            1);

        repeat (3) @(negedge clock);
        #1;
        chk("reset imem_req", 32'(imem_req), 32'd0);
        chk_reset_outputs("reset");

        for (int i = 0; i < 33; i++) begin
            cyc($sformatf("c%0d", i), 1'b0, tbl[i]);
        end

        // Reset clears the sticky fault and restarts at RESET_PC.
        cyc("flt_rst", 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 1));
        cyc("rs0", 1'b0, mk(1, 0, 0, 1, 32'h0, 0, 0, 0));
        chk_reset_outputs("rs0");
        cyc("rs1", 1'b0, mk(1, 0, 0, 1, 32'h4, 0, 0, 0));
        cyc("rs2", 1'b0, mk(1, 0, 0, 1, 32'h8, 1, 32'h0, 0));

        // Reset with a word in flight and one buffered; neither may surface.
        cyc("mid3", 1'b1, mk(1, 0, 0, 0, 0, 1, 32'h4, 0));
        cyc("mid4", 1'b1, mk(1, 0, 0, 0, 0, 0, 0, 0));
        chk_reset_outputs("mid4");
        cyc("mid5", 1'b0, mk(1, 0, 0, 1, 32'h0, 0, 0, 0));
        cyc("mid6", 1'b0, mk(1, 0, 0, 1, 32'h4, 0, 0, 0));
        cyc("mid7", 1'b0, mk(1, 0, 0, 1, 32'h8, 1, 32'h0, 0));
        cyc("mid8", 1'b0, mk(1, 0, 0, 1, 32'hC, 1, 32'h4, 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
